// File: rtl/match_ctrl.sv
// match_ctrl: match sequencing around the physics stage (frame divider, match FSM, scoring).
// Define MATCH_CTRL_DEUCE_EN to enable the win-by-two rule.
module match_ctrl #(
  parameter int unsigned FRAME_DIV    = 833333,
  parameter int unsigned SERVE_FRAMES = 30,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 15,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic               game_over,
  input  logic [1:0]         winner,
  input  logic               valid,
  output logic               phys_en,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [2:0]         state,
  output logic [1:0]         match_winner,
  output logic               serve_side
);

  localparam int unsigned FC_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned PH_MAX = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int unsigned PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(FRAME_DIV - 1);
  localparam logic [PH_W-1:0]    SERVE_LAST = PH_W'(SERVE_FRAMES - 1);
  localparam logic [PH_W-1:0]    PAUSE_LAST = PH_W'(PAUSE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE      = 3'd1,
    PLAY       = 3'd2,
    POINT      = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         mw_q, mw_d;
  logic               serve_q, serve_d;
  logic               tick_q, phys_q, btn_q;
  logic               fwrap, start_pulse, hit;
  logic               p1_wins, p2_wins;

  always_comb begin
    fwrap  = (fcnt_q == FC_LAST);
    fcnt_d = fwrap ? '0 : fcnt_q + FC_W'(1);
  end

`ifdef MATCH_CTRL_DEUCE_EN
  logic [SCORE_W:0] p1_ext, p2_ext;

  // Saturation ends the match outright; the leader is whoever sits at the ceiling.
  always_comb begin
    p1_ext  = {1'b0, p1_q};
    p2_ext  = {1'b0, p2_q};
    p1_wins = (p1_q == SCORE_MAX) ||
              ((p1_q >= WIN_S) && (p1_ext >= p2_ext + (SCORE_W+1)'(2)));
    p2_wins = (p2_q == SCORE_MAX) ||
              ((p2_q >= WIN_S) && (p2_ext >= p1_ext + (SCORE_W+1)'(2)));
  end
`else
  always_comb begin
    p1_wins = (p1_q >= WIN_S);
    p2_wins = (p2_q >= WIN_S);
  end
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    mw_d        = mw_q;
    serve_d     = serve_q;
    start_pulse = start_btn & ~btn_q;
    hit         = valid & game_over;

    unique case (state_q)
      IDLE, MATCH_OVER: begin
        if (start_pulse) begin
          p1_d    = '0;
          p2_d    = '0;
          mw_d    = 2'd0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if ((SERVE_FRAMES == 0) || (tick_q && (phase_q == SERVE_LAST))) begin
          state_d = PLAY;
        end else if (tick_q) begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      PLAY: begin
        if (hit && (winner == 2'd1)) begin
          p1_d    = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
          serve_d = 1'b0;
          state_d = POINT;
        end else if (hit && (winner == 2'd2)) begin
          p2_d    = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);
          serve_d = 1'b1;
          state_d = POINT;
        end
      end
      POINT: begin
        if ((PAUSE_FRAMES == 0) || (tick_q && (phase_q == PAUSE_LAST))) begin
          if (p1_wins) begin
            mw_d    = 2'd1;
            state_d = MATCH_OVER;
          end else if (p2_wins) begin
            mw_d    = 2'd2;
            state_d = MATCH_OVER;
          end else begin
            state_d = SERVE;
          end
        end else if (tick_q) begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) phase_d = '0;
  end

  // phys_en looks at the next state so a result landing on a tick cannot leak a pulse into POINT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      phase_q <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      mw_q    <= 2'd0;
      serve_q <= 1'b1;
      tick_q  <= 1'b0;
      phys_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      mw_q    <= mw_d;
      serve_q <= serve_d;
      tick_q  <= fwrap;
      phys_q  <= fwrap & (state_d == PLAY);
      btn_q   <= start_btn;
    end
  end

  assign phys_en      = phys_q;
  assign frame_tick   = tick_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign state        = state_q;
  assign match_winner = mw_q;
  assign serve_side   = serve_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: event-level match model, directed scenarios, random traffic.
module tb_match_ctrl;

  localparam int FD   = 4;
  localparam int SF   = 2;
  localparam int PF   = 3;
  localparam int WS   = 3;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_btn = 1'b0;
  logic          game_over = 1'b0;
  logic [1:0]    winner = 2'd0;
  logic          valid = 1'b0;
  logic          phys_en, frame_tick, serve_side;
  logic [SW-1:0] p1_score, p2_score;
  logic [2:0]    state;
  logic [1:0]    match_winner;

  int n_checks = 0;
  int n_err    = 0;
  bit done     = 1'b0;

  match_ctrl #(
    .FRAME_DIV(FD), .SERVE_FRAMES(SF), .PAUSE_FRAMES(PF), .WIN_SCORE(WS), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .game_over(game_over),
    .winner(winner), .valid(valid), .phys_en(phys_en), .frame_tick(frame_tick),
    .p1_score(p1_score), .p2_score(p2_score), .state(state),
    .match_winner(match_winner), .serve_side(serve_side)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cyc, m_p1, m_p2, m_state, m_mw, m_serve, m_left;
  bit m_tick, m_phys, m_btn_prev;

  function automatic int match_result(input int a, input int b);
`ifdef MATCH_CTRL_DEUCE_EN
    if (a == SMAX || b == SMAX) return (a > b) ? 1 : 2;
    if (a >= WS && a - b >= 2) return 1;
    if (b >= WS && b - a >= 2) return 2;
    return 0;
`else
    if (a >= WS) return 1;
    if (b >= WS) return 2;
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_tick = 0; m_phys = 0; m_p1 = 0; m_p2 = 0;
    m_state = 0; m_mw = 0; m_serve = 1; m_left = 0; m_btn_prev = 0;
  endtask

  task automatic phase_done();
    int w;
    if (m_state == 1) begin
      m_state = 2;
    end else begin
      w = match_result(m_p1, m_p2);
      if (w != 0) begin m_mw = w; m_state = 4; end
      else begin m_state = 1; m_left = SF; end
    end
  endtask

  task automatic model_step();
    bit pulse, hit;
    pulse = start_btn && !m_btn_prev;
    m_btn_prev = start_btn;
    hit = valid && game_over;
    case (m_state)
      0, 4: if (pulse) begin
        m_p1 = 0; m_p2 = 0; m_mw = 0; m_state = 1; m_left = SF;
      end
      1, 3: begin
        if (m_left == 0) phase_done();
        else if (m_tick) begin
          m_left--;
          if (m_left == 0) phase_done();
        end
      end
      2: begin
        if (hit && winner == 2'd1) begin
          m_p1 = (m_p1 < SMAX) ? m_p1 + 1 : SMAX; m_serve = 0; m_state = 3; m_left = PF;
        end else if (hit && winner == 2'd2) begin
          m_p2 = (m_p2 < SMAX) ? m_p2 + 1 : SMAX; m_serve = 1; m_state = 3; m_left = PF;
        end
      end
      default: ;
    endcase
    m_cyc++;
    m_tick = (m_cyc % FD) == 0;
    m_phys = m_tick && (m_state == 2);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("state", state, m_state);
        chk("p1_score", p1_score, m_p1);
        chk("p2_score", p2_score, m_p2);
        chk("match_winner", match_winner, m_mw);
        chk("serve_side", serve_side, m_serve);
        chk("frame_tick", frame_tick, m_tick);
        chk("phys_en", phys_en, m_phys);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_state(input int s, input int maxc, input string name);
    int n = 0;
    while (state != s && n < maxc) begin cyc(1); n++; end
    chk(name, state, s);
  endtask

  task automatic wait_phys(input int maxc);
    int n = 0;
    while (!phys_en && n < maxc) begin cyc(1); n++; end
    chk("phys_en_wait", phys_en, 1);
  endtask

  task automatic press();
    start_btn = 1'b1; cyc(1); start_btn = 1'b0;
  endtask

  // Physics answers one cycle after phys_en; score is visible one cycle after that.
  task automatic rally(input int w);
    wait_phys(200);
    cyc(1);
    valid = 1'b1; game_over = 1'b1; winner = 2'(w);
    cyc(1);
    valid = 1'b0; game_over = 1'b0; winner = 2'd0;
  endtask

  initial begin
    cyc(3);
    chk("reset_state", state, 0);
    chk("reset_serve_side", serve_side, 1);
    rst_n = 1'b1;
    cyc(2);

    // Start -> SERVE -> PLAY, then phys_en every FD cycles.
    press();
    chk("start_to_serve", state, 1);
    wait_state(2, 20, "serve_to_play");
    wait_phys(20);
    chk("phys_with_tick", frame_tick, 1);
    cyc(1);
    chk("phys_one_cycle", phys_en, 0);
    cyc(FD - 1);
    chk("phys_period", phys_en, 1);

    // P2 takes a point.
    rally(2);
    chk("t2_p2_score", p2_score, 1);
    chk("t2_serve_side", serve_side, 1);
    chk("t2_state_point", state, 3);
    wait_state(1, 40, "point_to_serve");
    wait_state(2, 40, "serve_to_play2");

    // Ignored results.
    valid = 1'b1; game_over = 1'b1; winner = 2'd0; cyc(1);
    winner = 2'd3; cyc(1);
    valid = 1'b0; winner = 2'd1; cyc(1);
    game_over = 1'b0; winner = 2'd0; cyc(1);
    chk("t3_p1_unchanged", p1_score, 0);
    chk("t3_p2_unchanged", p2_score, 1);
    chk("t3_still_play", state, 2);

    // P1 wins three rallies -> match over.
    rally(1);
    rally(1);
    rally(1);
    wait_state(4, 60, "match_over");
    chk("t4_match_winner", match_winner, 1);
    chk("t4_p1_score", p1_score, 3);
    start_btn = 1'b1;
    cyc(20);
    chk("t4_hold_state", state, 2);
    chk("t4_hold_p1", p1_score, 0);
    chk("t4_hold_mw", match_winner, 0);
    start_btn = 1'b0;
    cyc(1);

    // Reset mid-PLAY with p1=2.
    rally(1);
    rally(1);
    wait_state(2, 60, "t5_back_to_play");
    chk("t5_p1_before_reset", p1_score, 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_state", state, 0);
    chk("t5_rst_p1", p1_score, 0);
    chk("t5_rst_serve", serve_side, 1);
    chk("t5_rst_phys", phys_en, 0);
    chk("t5_rst_tick", frame_tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

`ifdef MATCH_CTRL_DEUCE_EN
    press();
    rally(1); rally(1); rally(2); rally(2); rally(1);
    wait_state(1, 40, "deuce_3_2_serve");
    chk("deuce_3_2_p1", p1_score, 3);
    chk("deuce_3_2_mw", match_winner, 0);
    rally(2);
    wait_state(1, 40, "deuce_3_3_serve");
    rally(1);
    wait_state(1, 40, "deuce_4_3_serve");
    chk("deuce_4_3_p1", p1_score, 4);
    rally(1);
    wait_state(4, 40, "deuce_match_over");
    chk("deuce_mw", match_winner, 1);
    chk("deuce_p1", p1_score, 5);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      start_btn = ($urandom_range(0, 5) == 0);
      valid     = ($urandom_range(0, 3) == 0);
      game_over = ($urandom_range(0, 1) == 0);
      winner    = 2'($urandom_range(0, 3));
      cyc(1);
    end
    rst_n = 1'b1; start_btn = 1'b0; valid = 1'b0; game_over = 1'b0; winner = 2'd0;
    cyc(2);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
